buffer_arbiter: RTL and testbench



---
 rtl/buffer_arbiter_if.sv | 45 ++++
 rtl/buffer_arbiter.sv | 152 +++++++++++++++
 tb/tb_buffer_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | Module   : buffer_arbiter_if                                             |
// | Brief    : Request/response bundle between the buffer arbiter and the    |
// |            RX, TX, AHB and protocol-controller clients.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface buffer_arbiter_if #(
  parameter int DEPTH = 64
);
  localparam int c_PW = $clog2(DEPTH) + 1;

  logic            clear;
  logic            rx_store;
  logic [7:0]      rx_byte;
  logic            tx_get;
  logic            ahb_req;
  logic            ahb_we;
  logic [7:0]      ahb_wdata;
  logic            ahb_gnt;
  logic [7:0]      ahb_rdata;
  logic            ahb_rvalid;
  logic            ahb_err;
  logic [7:0]      tx_byte;
  logic            tx_byte_valid;
  logic            tx_err;
  logic            rx_err;
  logic [c_PW-1:0] buffer_occupancy;
  logic            buffer_reserved;

  modport master (
    output clear, rx_store, rx_byte, tx_get, ahb_req, ahb_we, ahb_wdata,
    input  ahb_gnt, ahb_rdata, ahb_rvalid, ahb_err, tx_byte, tx_byte_valid,
    input  tx_err, rx_err, buffer_occupancy, buffer_reserved
  );

  modport slave (
    input  clear, rx_store, rx_byte, tx_get, ahb_req, ahb_we, ahb_wdata,
    output ahb_gnt, ahb_rdata, ahb_rvalid, ahb_err, tx_byte, tx_byte_valid,
    output tx_err, rx_err, buffer_occupancy, buffer_reserved
  );
endinterface

`default_nettype wire

// File: rtl/buffer_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : buffer_arbiter                                                |
// | Brief    : Single-port 64x8 endpoint buffer with fixed-priority access   |
// |            arbitration, FIFO pointers and direction ownership.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module buffer_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  buffer_arbiter_if.slave  bus
);

  localparam int            c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    AHB_FILL = 2'd1,
    TX_DRAIN = 2'd2,
    RX_FILL  = 2'd3
  } state_t;

  state_t        r_state;
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic [7:0]    r_mem [DEPTH];

  logic [7:0]    r_tx_byte;
  logic          r_tx_valid;
  logic          r_tx_err;
  logic          r_rx_err;
  logic [7:0]    r_ahb_rdata;
  logic          r_ahb_rvalid;
  logic          r_ahb_err;

  logic [c_AW:0] w_occ;
  logic          w_full;
  logic          w_empty;
  logic          w_last;
  logic          w_gnt;
  logic          w_rx_ok;
  logic          w_tx_ok;
  logic          w_ahb_wr_ok;
  logic          w_ahb_rd_ok;
  logic          w_mem_we;
  logic [7:0]    w_mem_wdata;
  logic [7:0]    w_rd_data;

  assign w_occ     = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_occ == c_FULL);
  assign w_empty   = (w_occ == '0);
  assign w_last    = (w_occ == (c_AW + 1)'(1));
  assign w_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

  // Only one of the *_ok strobes can be high: each lower requester is masked by every higher one.
  always_comb begin
    w_gnt       = bus.ahb_req & ~bus.clear & ~bus.rx_store & ~bus.tx_get;
    w_rx_ok     = 1'b0;
    w_tx_ok     = 1'b0;
    w_ahb_wr_ok = 1'b0;
    w_ahb_rd_ok = 1'b0;
    if (!bus.clear) begin
      w_rx_ok = bus.rx_store & ((r_state == FREE) | (r_state == RX_FILL)) & ~w_full;
      w_tx_ok = ~bus.rx_store & bus.tx_get
              & ((r_state == AHB_FILL) | (r_state == TX_DRAIN)) & ~w_empty;
    end
    w_ahb_wr_ok = w_gnt & bus.ahb_we & ((r_state == FREE) | (r_state == AHB_FILL)) & ~w_full;
    w_ahb_rd_ok = w_gnt & ~bus.ahb_we & (r_state == RX_FILL) & ~w_empty;
    w_mem_we    = w_rx_ok | w_ahb_wr_ok;
    w_mem_wdata = w_rx_ok ? bus.rx_byte : bus.ahb_wdata;
  end

  // Storage carries no reset; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= FREE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tx_byte    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_tx_err     <= 1'b0;
      r_rx_err     <= 1'b0;
      r_ahb_rdata  <= 8'h00;
      r_ahb_rvalid <= 1'b0;
      r_ahb_err    <= 1'b0;
    end else if (bus.clear) begin
      r_state      <= FREE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_err     <= 1'b0;
      r_rx_err     <= 1'b0;
      r_ahb_rvalid <= 1'b0;
      r_ahb_err    <= 1'b0;
    end else begin
      if (w_mem_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_tx_ok || w_ahb_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (w_rx_ok) begin
        r_state <= RX_FILL;
      end else if (w_tx_ok) begin
        r_state <= w_last ? FREE : TX_DRAIN;
      end else if (w_ahb_wr_ok) begin
        r_state <= AHB_FILL;
      end else if (w_ahb_rd_ok && w_last) begin
        r_state <= FREE;
      end

      r_rx_err   <= bus.rx_store & ~w_rx_ok;
      r_tx_valid <= bus.tx_get;
      r_tx_err   <= bus.tx_get & ~w_tx_ok;
      if (bus.tx_get) begin
        r_tx_byte <= w_tx_ok ? w_rd_data : 8'h00;
      end

      r_ahb_rvalid <= w_gnt;
      r_ahb_err    <= w_gnt & ~(w_ahb_wr_ok | w_ahb_rd_ok);
      // A write completion leaves the last read byte in place.
      if (w_gnt && !bus.ahb_we) begin
        r_ahb_rdata <= w_ahb_rd_ok ? w_rd_data : 8'h00;
      end
    end
  end

  assign bus.ahb_gnt          = w_gnt;
  assign bus.ahb_rdata        = r_ahb_rdata;
  assign bus.ahb_rvalid       = r_ahb_rvalid;
  assign bus.ahb_err          = r_ahb_err;
  assign bus.tx_byte          = r_tx_byte;
  assign bus.tx_byte_valid    = r_tx_valid;
  assign bus.tx_err           = r_tx_err;
  assign bus.rx_err           = r_rx_err;
  assign bus.buffer_occupancy = w_occ;
  assign bus.buffer_reserved  = (r_state == AHB_FILL) | (r_state == TX_DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_buffer_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_buffer_arbiter                                             |
// | Brief    : Self-checking bench: vector table, directed corner sequences  |
// |            and random traffic against a queue-based reference model.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_buffer_arbiter;

  localparam int DEPTH = 64;
  localparam int S_FREE = 0;
  localparam int S_AHB  = 1;
  localparam int S_TX   = 2;
  localparam int S_RX   = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  buffer_arbiter_if #(.DEPTH(DEPTH)) bus ();
  buffer_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: buffer contents as a plain byte queue plus an owner tag.
  logic [7:0] q[$];
  int         m_own;
  logic       m_txv, m_txerr, m_rxerr, m_rv, m_aerr;
  logic [7:0] m_txb, m_rd;

  typedef struct {
    bit         clr, rxs;
    logic [7:0] rxb;
    bit         txg, req, we;
    logic [7:0] wd;
    bit         e_gnt, e_txv, e_txerr;
    logic [7:0] e_txb;
    bit         e_rxerr, e_rv, e_aerr;
    logic [7:0] e_rd;
    int         e_occ;
    bit         e_res;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t v(bit clr, bit rxs, logic [7:0] rxb, bit txg, bit req, bit we,
                             logic [7:0] wd, bit gnt, bit txv, bit txerr, logic [7:0] txb,
                             bit rxerr, bit rv, bit aerr, logic [7:0] rd, int occ, bit res);
    vec_t r;
    r.clr = clr; r.rxs = rxs; r.rxb = rxb; r.txg = txg; r.req = req; r.we = we; r.wd = wd;
    r.e_gnt = gnt; r.e_txv = txv; r.e_txerr = txerr; r.e_txb = txb; r.e_rxerr = rxerr;
    r.e_rv = rv; r.e_aerr = aerr; r.e_rd = rd; r.e_occ = occ; r.e_res = res;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_own = S_FREE;
    m_txv = 0; m_txerr = 0; m_rxerr = 0; m_rv = 0; m_aerr = 0;
    m_txb = 8'h00; m_rd = 8'h00;
  endtask

  task automatic model(input bit clr, input bit rxs, input logic [7:0] rxb, input bit txg,
                       input bit req, input bit we, input logic [7:0] wd, output bit gnt);
    gnt = req && !clr && !rxs && !txg;
    m_txv = 0; m_txerr = 0; m_rxerr = 0; m_rv = 0; m_aerr = 0;
    if (clr) begin
      q.delete();
      m_own = S_FREE;
    end else begin
      if (rxs) begin
        if ((m_own == S_FREE || m_own == S_RX) && q.size() < DEPTH) begin
          q.push_back(rxb);
          m_own = S_RX;
        end else m_rxerr = 1;
      end
      if (txg) begin
        m_txv = 1;
        if (!rxs && (m_own == S_AHB || m_own == S_TX) && q.size() > 0) begin
          m_txb = q.pop_front();
          m_own = (q.size() == 0) ? S_FREE : S_TX;
        end else begin
          m_txerr = 1;
          m_txb = 8'h00;
        end
      end
      if (gnt) begin
        m_rv = 1;
        if (we) begin
          if ((m_own == S_FREE || m_own == S_AHB) && q.size() < DEPTH) begin
            q.push_back(wd);
            m_own = S_AHB;
          end else m_aerr = 1;
        end else if (m_own == S_RX && q.size() > 0) begin
          m_rd = q.pop_front();
          if (q.size() == 0) m_own = S_FREE;
        end else begin
          m_aerr = 1;
          m_rd = 8'h00;
        end
      end
    end
  endtask

  task automatic drive(input bit clr, input bit rxs, input logic [7:0] rxb, input bit txg,
                       input bit req, input bit we, input logic [7:0] wd);
    bus.clear = clr; bus.rx_store = rxs; bus.rx_byte = rxb; bus.tx_get = txg;
    bus.ahb_req = req; bus.ahb_we = we; bus.ahb_wdata = wd;
  endtask

  task automatic compare_model();
    chk("tx_byte_valid", 32'(bus.tx_byte_valid), 32'(m_txv));
    chk("tx_err", 32'(bus.tx_err), 32'(m_txerr));
    chk("tx_byte", 32'(bus.tx_byte), 32'(m_txb));
    chk("rx_err", 32'(bus.rx_err), 32'(m_rxerr));
    chk("ahb_rvalid", 32'(bus.ahb_rvalid), 32'(m_rv));
    chk("ahb_err", 32'(bus.ahb_err), 32'(m_aerr));
    chk("ahb_rdata", 32'(bus.ahb_rdata), 32'(m_rd));
    chk("occupancy", 32'(bus.buffer_occupancy), 32'(q.size()));
    chk("reserved", 32'(bus.buffer_reserved), 32'(m_own == S_AHB || m_own == S_TX));
  endtask

  // One clock: drive, check the combinational grant, clock, check registered outputs.
  task automatic cyc(input bit clr, input bit rxs, input logic [7:0] rxb, input bit txg,
                     input bit req, input bit we, input logic [7:0] wd, output bit gnt);
    drive(clr, rxs, rxb, txg, req, we, wd);
    model(clr, rxs, rxb, txg, req, we, wd, gnt);
    #1;
    chk("ahb_gnt", 32'(bus.ahb_gnt), 32'(gnt));
    @(posedge clk); #1;
    compare_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".tx_byte"}, 32'(bus.tx_byte), 0);
    chk({tag, ".tx_byte_valid"}, 32'(bus.tx_byte_valid), 0);
    chk({tag, ".tx_err"}, 32'(bus.tx_err), 0);
    chk({tag, ".rx_err"}, 32'(bus.rx_err), 0);
    chk({tag, ".ahb_rdata"}, 32'(bus.ahb_rdata), 0);
    chk({tag, ".ahb_rvalid"}, 32'(bus.ahb_rvalid), 0);
    chk({tag, ".ahb_err"}, 32'(bus.ahb_err), 0);
    chk({tag, ".occupancy"}, 32'(bus.buffer_occupancy), 0);
    chk({tag, ".reserved"}, 32'(bus.buffer_reserved), 0);
    chk({tag, ".ahb_gnt"}, 32'(bus.ahb_gnt), 0);
  endtask

  initial begin
    bit g;
    bit pend;
    bit r_clr, r_rxs, r_txg, r_req, r_we;
    logic [7:0] r_rxb, r_wd;

    drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
    model_reset();
    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    // clr rxs rxb txg req we wd | gnt txv txerr txb rxerr rv aerr rd occ res
    tbl.push_back(v(0,1,8'hA1,0,0,0,8'h00, 0,0,0,8'h00,0,0,0,8'h00,1,0));
    tbl.push_back(v(0,1,8'hB2,0,0,0,8'h00, 0,0,0,8'h00,0,0,0,8'h00,2,0));
    tbl.push_back(v(0,1,8'hC3,0,0,0,8'h00, 0,0,0,8'h00,0,0,0,8'h00,3,0));
    tbl.push_back(v(0,1,8'hD4,1,0,0,8'h00, 0,1,1,8'h00,0,0,0,8'h00,4,0));
    tbl.push_back(v(0,0,8'h00,0,1,1,8'h55, 1,0,0,8'h00,0,1,1,8'h00,4,0));
    tbl.push_back(v(0,1,8'hE5,0,1,0,8'h00, 0,0,0,8'h00,0,0,0,8'h00,5,0));
    tbl.push_back(v(0,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00,0,1,0,8'hA1,4,0));
    tbl.push_back(v(0,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00,0,1,0,8'hB2,3,0));
    tbl.push_back(v(0,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00,0,1,0,8'hC3,2,0));
    tbl.push_back(v(0,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00,0,1,0,8'hD4,1,0));
    tbl.push_back(v(0,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00,0,1,0,8'hE5,0,0));
    tbl.push_back(v(0,0,8'h00,1,0,0,8'h00, 0,1,1,8'h00,0,0,0,8'hE5,0,0));
    tbl.push_back(v(0,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00,0,1,1,8'h00,0,0));
    tbl.push_back(v(0,0,8'h00,0,1,1,8'h11, 1,0,0,8'h00,0,1,0,8'h00,1,1));
    tbl.push_back(v(0,1,8'h99,0,0,0,8'h00, 0,0,0,8'h00,1,0,0,8'h00,1,1));
    tbl.push_back(v(0,0,8'h00,0,1,0,8'h00, 1,0,0,8'h00,0,1,1,8'h00,1,1));
    tbl.push_back(v(0,0,8'h00,0,1,1,8'h22, 1,0,0,8'h00,0,1,0,8'h00,2,1));
    tbl.push_back(v(0,0,8'h00,1,0,0,8'h00, 0,1,0,8'h11,0,0,0,8'h00,1,1));
    tbl.push_back(v(0,0,8'h00,0,1,1,8'h33, 1,0,0,8'h11,0,1,1,8'h00,1,1));
    tbl.push_back(v(0,0,8'h00,1,0,0,8'h00, 0,1,0,8'h22,0,0,0,8'h00,0,0));
    tbl.push_back(v(0,0,8'h00,0,0,0,8'h00, 0,0,0,8'h22,0,0,0,8'h00,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].rxs, tbl[i].rxb, tbl[i].txg, tbl[i].req, tbl[i].we, tbl[i].wd);
      model(tbl[i].clr, tbl[i].rxs, tbl[i].rxb, tbl[i].txg, tbl[i].req, tbl[i].we, tbl[i].wd, g);
      #1;
      chk($sformatf("vec%0d.gnt", i), 32'(bus.ahb_gnt), 32'(tbl[i].e_gnt));
      @(posedge clk); #1;
      chk($sformatf("vec%0d.txv", i), 32'(bus.tx_byte_valid), 32'(tbl[i].e_txv));
      chk($sformatf("vec%0d.txerr", i), 32'(bus.tx_err), 32'(tbl[i].e_txerr));
      chk($sformatf("vec%0d.txb", i), 32'(bus.tx_byte), 32'(tbl[i].e_txb));
      chk($sformatf("vec%0d.rxerr", i), 32'(bus.rx_err), 32'(tbl[i].e_rxerr));
      chk($sformatf("vec%0d.rvalid", i), 32'(bus.ahb_rvalid), 32'(tbl[i].e_rv));
      chk($sformatf("vec%0d.aerr", i), 32'(bus.ahb_err), 32'(tbl[i].e_aerr));
      chk($sformatf("vec%0d.rdata", i), 32'(bus.ahb_rdata), 32'(tbl[i].e_rd));
      chk($sformatf("vec%0d.occ", i), 32'(bus.buffer_occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("vec%0d.res", i), 32'(bus.buffer_reserved), 32'(tbl[i].e_res));
    end

    // TX path: fill to full through AHB, overflow once, drain through TX.
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 8'h00, 0, 1, 1, 8'(i), g);
    chk("txpath.full_occ", 32'(bus.buffer_occupancy), 64);
    chk("txpath.full_res", 32'(bus.buffer_reserved), 1);
    cyc(0, 0, 8'h00, 0, 1, 1, 8'hEE, g);
    chk("txpath.overflow_err", 32'(bus.ahb_err), 1);
    chk("txpath.overflow_occ", 32'(bus.buffer_occupancy), 64);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 8'h00, 1, 0, 0, 8'h00, g);
      chk($sformatf("txpath.byte%0d", i), 32'(bus.tx_byte), 32'(i));
      chk($sformatf("txpath.res%0d", i), 32'(bus.buffer_reserved), (i == DEPTH - 1) ? 0 : 1);
    end

    // Clear while draining, with competing TX and AHB requests.
    for (int i = 0; i < 11; i++) cyc(0, 0, 8'h00, 0, 1, 1, 8'(8'h40 + i), g);
    cyc(0, 0, 8'h00, 1, 0, 0, 8'h00, g);
    chk("clear.pre_occ", 32'(bus.buffer_occupancy), 10);
    cyc(1, 0, 8'h00, 1, 1, 1, 8'hAA, g);
    chk("clear.gnt", 32'(g), 0);
    chk("clear.txerr", 32'(bus.tx_err), 0);
    chk("clear.aerr", 32'(bus.ahb_err), 0);
    chk("clear.occ", 32'(bus.buffer_occupancy), 0);
    chk("clear.res", 32'(bus.buffer_reserved), 0);
    cyc(0, 1, 8'h77, 0, 0, 0, 8'h00, g);
    chk("clear.rx_after_err", 32'(bus.rx_err), 0);
    chk("clear.rx_after_occ", 32'(bus.buffer_occupancy), 1);

    // Pointer wrap: paired store/read, occupancy never above one.
    cyc(1, 0, 8'h00, 0, 0, 0, 8'h00, g);
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1, 8'((i * 7 + 3) & 8'hFF), 0, 0, 0, 8'h00, g);
      chk($sformatf("wrap.occ_w%0d", i), 32'(bus.buffer_occupancy), 1);
      cyc(0, 0, 8'h00, 0, 1, 0, 8'h00, g);
      chk($sformatf("wrap.data%0d", i), 32'(bus.ahb_rdata), 32'((i * 7 + 3) & 8'hFF));
      chk($sformatf("wrap.occ_r%0d", i), 32'(bus.buffer_occupancy), 0);
    end

    // Random traffic; an AHB request is held until it is granted.
    pend = 0; r_req = 0; r_we = 0; r_wd = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode  = (i / 150) % 3;
      r_clr = ($urandom_range(0, 99) == 0);
      r_rxs = (mode == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
      r_txg = (mode == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) == 0);
      r_rxb = 8'($urandom);
      if (!pend) begin
        r_req = ($urandom_range(0, 2) != 0);
        r_we  = (mode == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 1) == 0);
        r_wd  = 8'($urandom);
      end
      cyc(r_clr, r_rxs, r_rxb, r_txg, r_req, r_we, r_wd, g);
      pend = r_req && !g;
    end

    // Asynchronous reset in the middle of traffic.
    cyc(1, 0, 8'h00, 0, 0, 0, 8'h00, g);
    cyc(0, 1, 8'h5A, 0, 0, 0, 8'h00, g);
    cyc(0, 0, 8'h00, 0, 1, 0, 8'h00, g);
    cyc(0, 1, 8'h6B, 1, 0, 0, 8'h00, g);
    chk("rst.pre_rdata", 32'(bus.ahb_rdata), 32'h5A);
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
    #2 n_rst = 1'b0;
    #1 check_all_zero("midrst");
    model_reset();
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    cyc(0, 1, 8'h3C, 0, 0, 0, 8'h00, g);
    chk("midrst.after_occ", 32'(bus.buffer_occupancy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
